pixel_fb_writer: RTL and testbench

Consumer end of the drawer pixel-coordinate stream. Accepts (x, y, color) pixels from a shape drawer over a valid/ready handshake and clips off-screen coordinates. Converts each on-screen pixel to a linear framebuffer address and issues one write per pixel to the framebuffer RAM write port. A small FIFO absorbs RAM back-pressure, so drawers can stream one pixel per clock.

---
 rtl/pixel_fb_writer.sv | 114 +++++++++++
 tb/tb_pixel_fb_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fb_writer.sv
// Pixel stream sink: clips, linearises and queues pixels
// for the framebuffer RAM write port.
module pixel_fb_writer #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        in_x,
  input  logic [10:0]        in_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  input  logic               mem_ready,
  output logic [15:0]        clip_count,
  output logic               idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + COLOR_W;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [EW-1:0]      mem_q [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [PW:0]        cnt_q, cnt_d;
  logic               en_q, en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [15:0]        clip_q, clip_d;

  logic               fifo_full, fifo_empty;
  logic               xfer, on_scr, push, pop;
  logic [ADDR_W-1:0]  lin_addr;
  logic [EW-1:0]      head;

  assign fifo_full  = (cnt_q == FULL);
  assign fifo_empty = (cnt_q == '0);
  assign in_ready   = reset & ~fifo_full;
  assign xfer       = in_valid & in_ready;
  assign on_scr     = (32'(in_x) < 32'(WIDTH)) &&
                      (32'(in_y) < 32'(HEIGHT));
  assign push       = xfer & on_scr;
  // Head moves out when the output slot is free or retiring now.
  assign pop        = ~fifo_empty & (~en_q | mem_ready);
  assign lin_addr   = ADDR_W'(32'(in_y) * 32'(WIDTH) + 32'(in_x));
  assign head       = mem_q[rptr_q];

  assign wr_en      = en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign clip_count = clip_q;
  assign idle       = fifo_empty & ~en_q;

  // Next-state for FIFO pointers, output slot and clip counter.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    addr_d = addr_q;
    data_d = data_q;
    clip_d = clip_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (pop) begin
      en_d   = 1'b1;
      addr_d = head[EW-1:COLOR_W];
      data_d = head[COLOR_W-1:0];
    end else if (mem_ready) begin
      en_d = 1'b0;
    end
    if (xfer && !on_scr && clip_q != 16'hFFFF)
      clip_d = clip_q + 16'd1;
  end

  // FIFO storage; holds no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {lin_addr, in_color};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      clip_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      clip_q <= clip_d;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Randomised + directed bench for pixel_fb_writer
// against a queue-based occupancy model.
module tb_pixel_fb_writer;
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int D  = 4;
  localparam int AW = 19;
  localparam int CW = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [10:0]   in_x = '0;
  logic [10:0]   in_y = '0;
  logic [CW-1:0] in_color = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          mem_ready = 1'b0;
  logic [15:0]   clip_count;
  logic          idle;

  pixel_fb_writer #(
    .WIDTH(W), .HEIGHT(H), .DEPTH(D),
    .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_ready(mem_ready), .clip_count(clip_count),
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int c; } px_t;

  px_t q[$];
  int  total = 0;
  int  bad = 0;
  int  n_m = 0;
  bit  out_m = 1'b0;
  int  clip_m = 0;
  int  writes = 0;
  int  first_a = -1;
  int  last_a = -1;
  bit  acc = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs already applied at the negedge.
  task automatic step();
    int done;
    int pushed;
    px_t p;
    #1;
    done = 0;
    pushed = 0;
    acc = 1'b0;
    if (!reset) begin
      chk("rdy_in_reset", 32'(in_ready), 0);
    end else begin
      chk("wr_en", 32'(wr_en), 32'(out_m));
      chk("in_ready", 32'(in_ready), 32'((n_m - int'(out_m)) < D));
      chk("idle", 32'(idle), 32'(n_m == 0));
      chk("clip", 32'(clip_count), clip_m);
      if (out_m) begin
        if (q.size() == 0) chk("model_empty", 1, 0);
        else begin
          chk("head_addr", 32'(wr_addr), q[0].a);
          chk("head_data", 32'(wr_data), q[0].c);
        end
      end
      if (out_m && mem_ready && q.size() > 0) begin
        p = q.pop_front();
        writes++;
        if (first_a < 0) first_a = p.a;
        last_a = p.a;
        done = 1;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        if (int'(in_x) < W && int'(in_y) < H) begin
          q.push_back('{int'(in_y) * W + int'(in_x), int'(in_color)});
          pushed = 1;
        end else if (clip_m < 65535) begin
          clip_m++;
        end
      end
    end
    @(posedge clk);
    if (!reset) begin
      q.delete();
      n_m = 0;
      out_m = 1'b0;
      clip_m = 0;
    end else begin
      out_m = (n_m - done) > 0;
      n_m = n_m - done + pushed;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic drive(int x, int y, int c);
    in_valid = 1'b1;
    in_x = 11'(x);
    in_y = 11'(y);
    in_color = CW'(c);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3 * D + 8; i++) begin
      if (n_m == 0) break;
      step();
    end
    chk("drain_left", n_m, 0);
    step();
  endtask

  int w0;
  int ac;
  int px;

  initial begin
    @(negedge clk);
    reset = 1'b0;
    step();
    do_reset();

    // 1: single pixel
    mem_ready = 1'b1;
    w0 = writes;
    drive(3, 2, 1);
    step();
    chk("t1_acc", 32'(acc), 1);
    in_valid = 1'b0;
    step();
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_addr", 32'(wr_addr), 1283);
    chk("t1_data", 32'(wr_data), 1);
    step();
    chk("t1_writes", writes - w0, 1);
    chk("t1_idle", 32'(idle), 1);

    // 2: 11x11 square
    w0 = writes;
    first_a = -1;
    px = 0;
    for (int i = 0; i < 200 && px < 121; i++) begin
      drive(20 + px % 11, 20 + px / 11, px & 1);
      step();
      if (!acc) chk("t2_stall", 1, 0);
      else px++;
    end
    chk("t2_sent", px, 121);
    drain();
    chk("t2_writes", writes - w0, 121);
    chk("t2_first", first_a, 12820);
    chk("t2_last", last_a, 19230);
    chk("t2_clip", 32'(clip_count), 0);

    // 3: back-pressure, capacity DEPTH+1
    mem_ready = 1'b0;
    w0 = writes;
    ac = 0;
    for (int i = 0; i < 10 && ac < 6; i++) begin
      drive(100 + ac, 7, ac & 1);
      step();
      if (acc) ac++;
    end
    chk("t3_accepted", ac, D + 1);
    chk("t3_ready", 32'(in_ready), 0);
    chk("t3_hold", 32'(wr_addr), 7 * W + 100);
    mem_ready = 1'b1;
    for (int i = 0; i < 10 && ac < 6; i++) begin
      step();
      if (acc) ac++;
    end
    chk("t3_sixth", ac, 6);
    drain();
    chk("t3_writes", writes - w0, 6);
    chk("t3_last", last_a, 7 * W + 105);

    // 4: clipping edges
    do_reset();
    w0 = writes;
    drive(640, 0, 1); step();
    drive(0, 480, 1); step();
    drive(639, 479, 1); step();
    drain();
    chk("t4_writes", writes - w0, 1);
    chk("t4_addr", last_a, 307199);
    chk("t4_clip", 32'(clip_count), 2);

    // 5: reset discards queued pixels
    mem_ready = 1'b0;
    w0 = writes;
    for (int i = 0; i < 3; i++) begin
      drive(10 + i, 10, 1);
      step();
    end
    do_reset();
    step();
    chk("t5_wr_en", 32'(wr_en), 0);
    chk("t5_idle", 32'(idle), 1);
    chk("t5_clip", 32'(clip_count), 0);
    mem_ready = 1'b1;
    repeat (5) step();
    chk("t5_writes", writes - w0, 0);

    // 6: clip counter saturation
    drive(700, 5, 0);
    for (int i = 0; i < 65534; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("t6_pre", 32'(clip_count), 65534);
    for (int i = 0; i < 3; i++) step();
    chk("t6_sat", 32'(clip_count), 65535);
    in_valid = 1'b0;
    step();
    chk("t6_hold", 32'(clip_count), 65535);

    // Random traffic with stalls and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        in_x = 11'($urandom_range(0, 2047));
        in_y = 11'($urandom_range(0, 2047));
      end else begin
        in_x = 11'($urandom_range(0, 700));
        in_y = 11'($urandom_range(0, 520));
      end
      in_color = CW'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 499) != 0);
      step();
      reset = 1'b1;
    end
    drain();
    chk("rand_q_empty", q.size(), 0);
    chk("rand_idle", 32'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
